sobol_idx_gen: RTL and testbench

- Upstream scheduler for the sobol stage: emits (idx, dim) request pairs over a valid/ready handshake, one per cycle when not stalled.
- Ordering is path-major, dimension-minor: for each path p in 0..num_paths-1, emits dims 0..num_dims-1 with idx = base + p.
- Each sobol_out therefore lands in the per-path, per-time-step order the LSM path builder consumes.
- Started by a one-cycle start pulse; signals completion with a done pulse.

---
 rtl/sobol_idx_gen.sv | 175 +++++++++++++++++
 tb/tb_sobol_idx_gen.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sobol_idx_gen.sv
// -----------------------------------------------------------------------------
// sobol_idx_gen
//
// Upstream scheduler for the Sobol stage. A run is started with a one-cycle
// i_start pulse. It then issues (idx, dim) request pairs over a valid/ready
// handshake in path-major, dimension-minor order:
//   for p in 0..np-1: for d in 0..nd-1: emit (base + p, d)
// At most one pair is issued per cycle. There is no bubble between accepted
// pairs. The end of each run, normal or aborted, is marked by a one-cycle
// o_done pulse.
//
// Optional feature: when SOBOL_IDX_SKIP_EN is defined, the port i_skip_in is
// added. Its value is latched on start and used as the base index. Without the
// macro the base index is 0.
//
// Ports
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   i_start       in   start pulse, honoured only in IDLE
//   i_num_paths   in   [WIDTH]        number of paths (indices) to issue
//   i_num_dims    in   [clog2(M+1)]   dimensions per path, clamped to M
//   i_skip_in     in   [WIDTH]        base index (SOBOL_IDX_SKIP_EN only)
//   i_abort       in   terminates an active run
//   o_valid_out   out  request valid
//   i_ready_in    in   downstream accept
//   o_idx_out     out  [WIDTH]        Sobol index
//   o_dim_out     out  [clog2(M)]     dimension
//   o_busy        out  high while in RUN
//   o_done        out  one-cycle end-of-run pulse
// -----------------------------------------------------------------------------
module sobol_idx_gen #(
    parameter int WIDTH = 32,
    parameter int M     = 50
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_start,
    input  logic [WIDTH-1:0]           i_num_paths,
    input  logic [$clog2(M+1)-1:0]     i_num_dims,
`ifdef SOBOL_IDX_SKIP_EN
    input  logic [WIDTH-1:0]           i_skip_in,
`endif
    input  logic                       i_abort,
    output logic                       o_valid_out,
    input  logic                       i_ready_in,
    output logic [WIDTH-1:0]           o_idx_out,
    output logic [$clog2(M)-1:0]       o_dim_out,
    output logic                       o_busy,
    output logic                       o_done
);

    localparam int DW  = $clog2(M);
    localparam int NDW = $clog2(M+1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state, w_state_next;
    logic [WIDTH-1:0] r_np,    w_np_next;
    logic [NDW-1:0]   r_nd,    w_nd_next;
    logic [WIDTH-1:0] r_base,  w_base_next;
    logic [WIDTH-1:0] r_path_cnt, w_path_next;
    logic [DW-1:0]    r_dim_cnt,  w_dim_next;
    logic             r_valid, w_valid_next;
    logic [WIDTH-1:0] r_idx,   w_idx_next;

    logic [WIDTH-1:0] w_base_in;
    logic [NDW-1:0]   w_nd_clamped;
    logic             w_accept;
    logic             w_last_dim;
    logic             w_last_path;

`ifdef SOBOL_IDX_SKIP_EN
    assign w_base_in = i_skip_in;
`else
    assign w_base_in = '0;
`endif

    assign w_nd_clamped = (i_num_dims > NDW'(M)) ? NDW'(M) : i_num_dims;
    assign w_accept     = r_valid & i_ready_in;
    assign w_last_dim   = (NDW'(r_dim_cnt) == (r_nd - NDW'(1)));
    assign w_last_path  = (r_path_cnt == (r_np - WIDTH'(1)));

    always_comb begin
        w_state_next = r_state;
        w_np_next    = r_np;
        w_nd_next    = r_nd;
        w_base_next  = r_base;
        w_path_next  = r_path_cnt;
        w_dim_next   = r_dim_cnt;
        w_valid_next = r_valid;
        w_idx_next   = r_idx;

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_np_next   = i_num_paths;
                    w_nd_next   = w_nd_clamped;
                    w_base_next = w_base_in;
                    w_path_next = '0;
                    w_dim_next  = '0;
                    w_idx_next  = w_base_in;
                    if ((i_num_paths == '0) || (w_nd_clamped == '0)) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_state_next = S_RUN;
                        w_valid_next = 1'b1;
                    end
                end
            end

            S_RUN: begin
                // Abort wins over advancing; a pair accepted on the same edge
                // is already delivered downstream and needs no bookkeeping.
                if (i_abort) begin
                    w_valid_next = 1'b0;
                    w_state_next = S_DONE;
                end else if (w_accept) begin
                    if (w_last_dim && w_last_path) begin
                        w_valid_next = 1'b0;
                        w_state_next = S_DONE;
                    end else if (!w_last_dim) begin
                        w_dim_next = r_dim_cnt + DW'(1);
                    end else begin
                        w_dim_next  = '0;
                        w_path_next = r_path_cnt + WIDTH'(1);
                        // Index wraps modulo 2^WIDTH by construction.
                        w_idx_next  = r_base + r_path_cnt + WIDTH'(1);
                    end
                end
            end

            S_DONE: begin
                w_state_next = S_IDLE;
            end

            default: begin
                w_state_next = S_IDLE;
                w_valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_np       <= '0;
            r_nd       <= '0;
            r_base     <= '0;
            r_path_cnt <= '0;
            r_dim_cnt  <= '0;
            r_valid    <= 1'b0;
            r_idx      <= '0;
        end else begin
            r_state    <= w_state_next;
            r_np       <= w_np_next;
            r_nd       <= w_nd_next;
            r_base     <= w_base_next;
            r_path_cnt <= w_path_next;
            r_dim_cnt  <= w_dim_next;
            r_valid    <= w_valid_next;
            r_idx      <= w_idx_next;
        end
    end

    assign o_valid_out = r_valid;
    assign o_idx_out   = r_idx;
    assign o_dim_out   = r_dim_cnt;
    assign o_busy      = (r_state == S_RUN);
    assign o_done      = (r_state == S_DONE);

endmodule

// File: tb/tb_sobol_idx_gen.sv
// -----------------------------------------------------------------------------
// tb_sobol_idx_gen
//
// Self-checking bench for sobol_idx_gen. For each run the expected pair
// sequence is built as a list, using nested path/dimension loops over the
// clamped run parameters. Each accepted pair is then compared with the next
// entry of that list. The bench also checks the valid level on every cycle,
// the done pulse and the busy level.
// -----------------------------------------------------------------------------
module tb_sobol_idx_gen;

    localparam int WIDTH = 32;
    localparam int M     = 50;
    localparam int DW    = $clog2(M);
    localparam int NDW   = $clog2(M+1);

    logic                 clk;
    logic                 rst_n;
    logic                 i_start;
    logic [WIDTH-1:0]     i_num_paths;
    logic [NDW-1:0]       i_num_dims;
    logic [WIDTH-1:0]     i_skip_in;
    logic                 i_abort;
    logic                 o_valid_out;
    logic                 i_ready_in;
    logic [WIDTH-1:0]     o_idx_out;
    logic [DW-1:0]        o_dim_out;
    logic                 o_busy;
    logic                 o_done;

    int n_checks;
    int n_passed;

    logic [WIDTH-1:0] tb_base;

    sobol_idx_gen #(.WIDTH(WIDTH), .M(M)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (i_start),
        .i_num_paths (i_num_paths),
        .i_num_dims  (i_num_dims),
`ifdef SOBOL_IDX_SKIP_EN
        .i_skip_in   (i_skip_in),
`endif
        .i_abort     (i_abort),
        .o_valid_out (o_valid_out),
        .i_ready_in  (i_ready_in),
        .o_idx_out   (o_idx_out),
        .o_dim_out   (o_dim_out),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_passed++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete run. Call it just after a falling edge.
    //   stall_n    : hold ready low for the first stall_n valid cycles
    //   rdy_pct    : probability (percent) of ready afterwards
    //   abort_at   : abort together with the acceptance of pair number abort_at (1-based), 0 = none
    //   restart_at : loop cycle at which a spurious start is pulsed, -1 = none
    task automatic run_job(input string name, input int np, input int ndreq,
                           input int stall_n, input int rdy_pct,
                           input int abort_at, input int restart_at);
        logic [WIDTH-1:0] exp_idx[$];
        int               exp_dim[$];
        int nd, total, limit, delivered, stall_left, done_cyc;
        bit seen_done;
        nd = (ndreq > M) ? M : ndreq;
        for (int p = 0; p < np; p++)
            for (int d = 0; d < nd; d++) begin
                exp_idx.push_back(tb_base + WIDTH'(p));
                exp_dim.push_back(d);
            end
        total = exp_idx.size();
        limit = (abort_at > 0 && abort_at < total) ? abort_at : total;

        i_start     = 1'b1;
        i_num_paths = WIDTH'(np);
        i_num_dims  = NDW'(ndreq);
        i_skip_in   = tb_base;
        @(negedge clk);
        i_start     = 1'b0;
        i_num_paths = WIDTH'($urandom);   // mid-run changes must be ignored
        i_num_dims  = NDW'($urandom_range(63));

        delivered  = 0;
        stall_left = stall_n;
        seen_done  = 0;
        done_cyc   = -1;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            if (o_done) begin
                seen_done = 1;
                done_cyc  = cyc;
                break;
            end
            check({name, " valid"}, 64'(o_valid_out), 64'(delivered < limit));
            check({name, " busy"}, 64'(o_busy), 64'(delivered < limit));
            if (o_valid_out && delivered < total) begin
                check({name, " idx"}, 64'(o_idx_out), 64'(exp_idx[delivered]));
                check({name, " dim"}, 64'(o_dim_out), 64'(exp_dim[delivered]));
            end
            if (o_valid_out && stall_left > 0) begin
                i_ready_in = 1'b0;
                stall_left--;
            end else begin
                i_ready_in = ($urandom_range(99) < rdy_pct);
            end
            i_abort = (abort_at > 0 && o_valid_out && i_ready_in && delivered == abort_at - 1);
            i_start = (cyc == restart_at);
            if (o_valid_out && i_ready_in) delivered++;
            @(negedge clk);
            i_abort = 1'b0;
            i_start = 1'b0;
        end
        check({name, " done_seen"}, 64'(seen_done), 64'd1);
        check({name, " delivered"}, 64'(delivered), 64'(limit));
        check({name, " valid_at_done"}, 64'(o_valid_out), 64'd0);
        if (rdy_pct == 100 && stall_n == 0 && abort_at == 0)
            check({name, " done_cycle"}, 64'(done_cyc), 64'(total));
        @(negedge clk);
        check({name, " done_pulse"}, 64'(o_done), 64'd0);
        check({name, " busy_after"}, 64'(o_busy), 64'd0);
        $display("run %s np=%0d nd=%0d delivered=%0d done_cycle=%0d", name, np, ndreq, delivered, done_cyc);
    endtask

    initial begin
        n_checks    = 0;
        n_passed    = 0;
        tb_base     = '0;
        rst_n       = 1'b0;
        i_start     = 1'b0;
        i_num_paths = '0;
        i_num_dims  = '0;
        i_skip_in   = '0;
        i_abort     = 1'b0;
        i_ready_in  = 1'b0;

`ifdef SOBOL_IDX_SKIP_EN
        tb_base = 32'd1;
`endif

        repeat (2) @(negedge clk);
        check("rst valid", 64'(o_valid_out), 64'd0);
        check("rst busy", 64'(o_busy), 64'd0);
        check("rst done", 64'(o_done), 64'd0);
        check("rst idx", 64'(o_idx_out), 64'd0);
        check("rst dim", 64'(o_dim_out), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_job("basic", 2, 3, 0, 100, 0, -1);
        run_job("backpressure", 1, 2, 3, 100, 0, -1);
        run_job("zero_paths", 0, 3, 0, 100, 0, -1);
        run_job("zero_dims", 3, 0, 0, 100, 0, -1);
        run_job("clamp", 2, 63, 0, 100, 0, -1);
        run_job("abort3", 1, 10, 0, 100, 3, -1);
        run_job("restart_ignored", 2, 4, 0, 100, 0, 2);

        // Abort while idle must not create a done pulse.
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        check("idle_abort done", 64'(o_done), 64'd0);
        check("idle_abort busy", 64'(o_busy), 64'd0);
        $display("idle abort pulse done=%0b busy=%0b", o_done, o_busy);

        for (int k = 0; k < 6; k++) begin
            int np_r, nd_r, ab;
            np_r = $urandom_range(6, 1);
            nd_r = $urandom_range(63);
            ab   = ($urandom_range(2) == 0) ? $urandom_range(np_r * ((nd_r > M) ? M : nd_r) + 1, 1) : 0;
            run_job("random", np_r, nd_r, $urandom_range(3), 70, ab, -1);
        end

        // Reset mid-run, asserted away from any clock edge.
        i_start     = 1'b1;
        i_num_paths = 32'd5;
        i_num_dims  = NDW'(4);
        i_skip_in   = tb_base;
        i_ready_in  = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_reset valid", 64'(o_valid_out), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset valid", 64'(o_valid_out), 64'd0);
        check("async_reset busy", 64'(o_busy), 64'd0);
        check("async_reset done", 64'(o_done), 64'd0);
        $display("async reset valid=%0b busy=%0b done=%0b", o_valid_out, o_busy, o_done);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_job("after_reset", 2, 2, 0, 100, 0, -1);

`ifdef SOBOL_IDX_SKIP_EN
        tb_base = 32'hFFFF_FFFF;
        run_job("skip_wrap", 2, 1, 0, 100, 0, -1);
`endif

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
